// File: rtl/cci_mpf_prim_rob_arb_pkg.sv
`default_nettype none
// ============================================================================
// cci_mpf_prim_rob_arb_pkg : shared types for the ROB arbiter and its rspq
// Revision: 1.0
// ============================================================================
package cci_mpf_prim_rob_arb_pkg;

    localparam int RSPQ_DEPTH   = 4;
    localparam int RSPQ_PTR_W   = $clog2(RSPQ_DEPTH);
    localparam int MAX_REQ_ID_W = 2;
    localparam int OUT_CNT_W    = 16;

    typedef logic [MAX_REQ_ID_W-1:0] t_req_id;
    typedef logic [OUT_CNT_W-1:0]    t_out_cnt;
    typedef logic [RSPQ_PTR_W:0]     t_rspq_cnt;
    typedef logic [RSPQ_PTR_W-1:0]   t_rspq_ptr;

    // Round-robin successor with wrap at n-1
    function automatic t_req_id rr_next(input t_req_id id, input int n);
        return (int'(id) == n - 1) ? '0 : id + 1'b1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/cci_mpf_prim_rob_arb_rspq.sv
`default_nettype none
// ============================================================================
// cci_mpf_prim_rob_arb_rspq : 4-entry response FIFO, head held in flops
// Revision: 1.0
// ============================================================================
module cci_mpf_prim_rob_arb_rspq
    import cci_mpf_prim_rob_arb_pkg::*;
#(
    parameter int WIDTH = 8
)(
    input  logic             clk,
    input  logic             reset_n,
    input  logic             enq_en,
    input  logic [WIDTH-1:0] enq_data,
    input  logic             deq_en,
    output logic             not_empty,
    output logic [WIDTH-1:0] first,
    output t_rspq_cnt        count
);

    logic [WIDTH-1:0] r_mem [RSPQ_DEPTH];
    t_rspq_ptr        r_rd_ptr;
    t_rspq_ptr        r_wr_ptr;
    t_rspq_cnt        r_count;
    logic             w_deq;

    assign w_deq = deq_en && not_empty;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
            for (int i = 0; i < RSPQ_DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            // When full, a simultaneous pop frees the slot the write lands in
            if (enq_en) begin
                r_mem[r_wr_ptr] <= enq_data;
                r_wr_ptr        <= r_wr_ptr + 1'b1;
            end
            if (w_deq) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            r_count <= r_count + t_rspq_cnt'(enq_en) - t_rspq_cnt'(w_deq);
        end
    end

    assign not_empty = (r_count != '0);
    assign first     = r_mem[r_rd_ptr];
    assign count     = r_count;

endmodule
`default_nettype wire

// File: rtl/cci_mpf_prim_rob_arb.sv
`default_nettype none
// ============================================================================
// cci_mpf_prim_rob_arb : round-robin ROB allocation arbiter with in-order
//                        response delivery through a credit-checked queue
// Revision: 1.0
// ============================================================================
module cci_mpf_prim_rob_arb
    import cci_mpf_prim_rob_arb_pkg::*;
#(
    parameter int N_ENTRIES        = 32,
    parameter int N_DATA_BITS      = 64,
    parameter int N_USER_META_BITS = 8,
    parameter int N_REQ            = 2,
    parameter int MAX_OUTSTANDING  = 16
)(
    input  logic                                       clk,
    input  logic                                       reset_n,
    input  logic [N_REQ-1:0]                           req_alloc,
    input  logic [N_REQ-1:0][N_USER_META_BITS-1:0]     req_meta,
    output logic [N_REQ-1:0]                           req_grant,
    output logic [$clog2(N_ENTRIES)-1:0]               req_idx,
    output logic                                       rob_alloc,
    output logic [$clog2(N_REQ)+N_USER_META_BITS-1:0]  rob_allocMeta,
    input  logic                                       rob_notFull,
    input  logic [$clog2(N_ENTRIES)-1:0]               rob_allocIdx,
    input  logic                                       rob_notEmpty,
    output logic                                       rob_deq_en,
    input  logic [N_DATA_BITS-1:0]                     rob_T2_first,
    input  logic [$clog2(N_REQ)+N_USER_META_BITS-1:0]  rob_T2_firstMeta,
    output logic [N_REQ-1:0]                           rsp_valid,
    input  logic [N_REQ-1:0]                           rsp_ready,
    output logic [N_DATA_BITS-1:0]                     rsp_data,
    output logic [N_USER_META_BITS-1:0]                rsp_meta
);

    localparam int       c_id_w    = $clog2(N_REQ);
    localparam int       c_meta_w  = c_id_w + N_USER_META_BITS;
    localparam int       c_ent_w   = c_meta_w + N_DATA_BITS;
    localparam t_out_cnt c_max_out = t_out_cnt'(MAX_OUTSTANDING);

    t_out_cnt                    r_out_cnt [N_REQ];
    t_req_id                     r_rr_ptr;
    logic [1:0]                  r_t2_vld;

    logic [N_REQ-1:0]            w_elig;
    logic [N_REQ-1:0]            w_grant;
    logic [N_REQ-1:0]            w_fire;
    t_req_id                     w_gid;
    logic [N_USER_META_BITS-1:0] w_gtag;
    logic                        w_found;
    int                          w_scan;
    logic [1:0]                  w_inflight;
    logic [3:0]                  w_need;
    t_rspq_cnt                   w_q_count;
    logic                        w_head_vld;
    logic [c_ent_w-1:0]          w_head;
    logic [c_id_w-1:0]           w_head_id;

    for (genvar i = 0; i < N_REQ; i++) begin : g_elig
        assign w_elig[i] = reset_n && req_alloc[i] && rob_notFull &&
                           (r_out_cnt[i] < c_max_out);
    end

    // Scan starts at the round-robin pointer; first eligible requester wins
    always_comb begin
        w_grant = '0;
        w_gid   = '0;
        w_gtag  = '0;
        w_found = 1'b0;
        w_scan  = 0;
        for (int k = 0; k < N_REQ; k++) begin
            w_scan = int'(r_rr_ptr) + k;
            if (w_scan >= N_REQ) begin
                w_scan = w_scan - N_REQ;
            end
            for (int i = 0; i < N_REQ; i++) begin
                if (!w_found && (i == w_scan) && w_elig[i]) begin
                    w_found    = 1'b1;
                    w_grant[i] = 1'b1;
                    w_gid      = t_req_id'(i);
                    w_gtag     = req_meta[i];
                end
            end
        end
    end

    assign req_grant     = w_grant;
    assign rob_alloc     = |w_grant;
    assign rob_allocMeta = {w_gid[c_id_w-1:0], w_gtag};
    assign req_idx       = rob_allocIdx;

    // Reserve queue space for every deq still in the T2 pipe
    assign w_inflight = {1'b0, r_t2_vld[0]} + {1'b0, r_t2_vld[1]};
    assign w_need     = {1'b0, w_q_count} + {2'b00, w_inflight} + 4'd1;
    assign rob_deq_en = reset_n && rob_notEmpty && (w_need <= 4'(RSPQ_DEPTH));

    cci_mpf_prim_rob_arb_rspq #(
        .WIDTH (c_ent_w)
    ) rspq (
        .clk       (clk),
        .reset_n   (reset_n),
        .enq_en    (r_t2_vld[1]),
        .enq_data  ({rob_T2_firstMeta, rob_T2_first}),
        .deq_en    (|w_fire),
        .not_empty (w_head_vld),
        .first     (w_head),
        .count     (w_q_count)
    );

    assign w_head_id = w_head[c_ent_w-1 -: c_id_w];
    assign rsp_meta  = w_head[N_DATA_BITS +: N_USER_META_BITS];
    assign rsp_data  = w_head[N_DATA_BITS-1:0];

    for (genvar i = 0; i < N_REQ; i++) begin : g_rsp
        assign rsp_valid[i] = w_head_vld && (w_head_id == c_id_w'(i));
    end
    assign w_fire = rsp_valid & rsp_ready;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_rr_ptr <= '0;
            r_t2_vld <= '0;
            for (int i = 0; i < N_REQ; i++) begin
                r_out_cnt[i] <= '0;
            end
        end else begin
            if (rob_alloc) begin
                r_rr_ptr <= rr_next(w_gid, N_REQ);
            end
            r_t2_vld <= {r_t2_vld[0], rob_deq_en};
            for (int i = 0; i < N_REQ; i++) begin
                case ({w_grant[i], w_fire[i]})
                    2'b10:   r_out_cnt[i] <= r_out_cnt[i] + t_out_cnt'(1);
                    2'b01:   r_out_cnt[i] <= r_out_cnt[i] - t_out_cnt'(1);
                    default: r_out_cnt[i] <= r_out_cnt[i];
                endcase
            end
        end
    end

endmodule
`default_nettype wire

// File: doc/cci_mpf_prim_rob_arb.md
CCI_MPF_PRIM_ROB_ARB -- requirements
Module: cci_mpf_prim_rob_arb

Interface
REQ-001 SHALL have parameter N_ENTRIES, default 32, meaning ROB depth (power of 2).
REQ-002 SHALL have parameter N_DATA_BITS, default 64, meaning ROB payload width.
REQ-003 SHALL have parameter N_USER_META_BITS, default 8, meaning per-request user tag width.
REQ-004 SHALL have parameter N_REQ, default 2, meaning number of requesters (2..4).
REQ-005 SHALL have parameter MAX_OUTSTANDING, default 16, meaning per-requester in-flight limit (1..N_ENTRIES).
REQ-006 SHALL have one clock and an asynchronous, active-low reset, with ports clk and reset_n.
REQ-007 clk  input  1  clock.
REQ-008 reset_n  input  1  asynchronous active-low reset.
REQ-009 req_alloc  input  N_REQ  per-requester allocation request.
REQ-010 req_meta  input  N_REQ x N_USER_META_BITS  per-requester user tag.
REQ-011 req_grant  output  N_REQ  one-hot grant, combinational.
REQ-012 req_idx  output  log2(N_ENTRIES)  ROB index for the granted request.
REQ-013 rob_alloc  output  1  ROB allocate; rob_allocMeta  output  log2(N_REQ)+N_USER_META_BITS  {requester id, tag}.
REQ-014 rob_notFull  input  1; rob_allocIdx  input  log2(N_ENTRIES); rob_notEmpty  input  1; rob_deq_en  output  1.
REQ-015 rob_T2_first  input  N_DATA_BITS; rob_T2_firstMeta  input  log2(N_REQ)+N_USER_META_BITS.
REQ-016 rsp_valid  output  N_REQ; rsp_ready  input  N_REQ; rsp_data  output  N_DATA_BITS; rsp_meta  output  N_USER_META_BITS.

Function
REQ-017 SHALL grant at most one requester per cycle, round-robin, starting the search one past the last granted id.
REQ-018 SHALL grant requester i only when req_alloc[i], rob_notFull=1 and out_cnt[i] < MAX_OUTSTANDING.
REQ-019 SHALL drive rob_alloc = OR(req_grant), rob_allocMeta = {i, req_meta[i]}, and req_idx = rob_allocIdx in the same cycle as the grant.
REQ-020 SHALL increment out_cnt[i] on grant to i, decrement on rsp_valid[i] and rsp_ready[i]; when both occur in one cycle the count SHALL be unchanged.
REQ-021 SHALL contain a 4-entry response queue of {id, tag, data}.
REQ-022 SHALL track inflight (0..2), the number of deqs whose T2 data has not yet arrived.
REQ-023 SHALL assert rob_deq_en only when rob_notEmpty=1 and queue_count + inflight + 1 <= 4, so the queue never overflows.
REQ-024 SHALL write rob_T2_first/rob_T2_firstMeta into the queue exactly 2 cycles after each rob_deq_en, through a 2-stage valid shift register.
REQ-025 SHALL present the queue head on rsp_valid[id] (one-hot), rsp_data and rsp_meta; all other rsp_valid bits SHALL be 0.
REQ-026 SHALL pop the head on rsp_ready[id]; other requesters SHALL wait behind the head (strict ROB order).
REQ-027 SHALL support a queue write and a pop in the same cycle when the queue is full or empty; an empty-queue write SHALL reach rsp_valid the next cycle (no bypass).
REQ-028 The round-robin pointer SHALL wrap from N_REQ-1 to 0 and SHALL advance only on grant.

Reset
REQ-029 On reset_n=0, the following SHALL clear asynchronously: out_cnt, round-robin pointer (0), queue, inflight, T2 pipeline, rsp_valid=0 and rob_deq_en=0.
REQ-030 req_grant and rob_alloc SHALL be 0 while reset_n=0.
REQ-031 T2 returns pending at reset SHALL be discarded; the integrator SHALL reset the ROB (active-high, synchronous, driven from the inverse of reset_n) in the same window.

Structure
REQ-032 Package cci_mpf_prim_rob_arb_pkg SHALL hold t_req_id, t_out_cnt and the constant RSPQ_DEPTH=4.
REQ-033 The response queue SHALL be sub-module cci_mpf_prim_rob_arb_rspq, with an async active-low reset and a registered head.

Verification
REQ-034 Both requesters hold req_alloc=1, ROB empty -> grants alternate 0,1,0,1; req_idx = 0,1,2,3.
REQ-035 MAX_OUTSTANDING=2, requester 0 alone, never ready -> exactly 2 grants, then req_grant[0]=0 until a response handshake.
REQ-036 rob_notFull=0 with req_alloc=2'b11 -> req_grant=0 and rob_alloc=0.
REQ-037 4 entries ready, rsp_ready=0 -> exactly 4 rob_deq_en pulses, then rob_deq_en=0; raising rsp_ready pops them in ROB order.
REQ-038 Head id=1 with rsp_ready=2'b01 -> the head stalls and the id=0 entry behind it is not delivered.
REQ-039 reset_n pulled low with 2 deqs in flight -> outputs zero immediately; after release, no stale response appears.
